kmeans_iter_ctrl: RTL and testbench
===================================

// Module: kmeans_iter_ctrl
// PURPOSE
//  Top-level sequencer of the k-means core, and successor to the single-pass controller.
//  Runs full iterations autonomously: classify pass, pipeline drain, per-centroid divide and
//  convergence check, repeated until convergence or MAX_ITER.
//  Generalised in centroid count, pipe depth and divider latency; adds abort, wrap-around
//  addressing, iteration count and a busy/done handshake.
// PARAMETERS
//  CENT_NUM   8   number of centroids
//  CENT_W     3   $clog2(CENT_NUM), width of centroid index
//  ADDR_W     9   point-RAM address width
//  PIPE_DEPTH 3   cycles from input reg to accumulator enable (classification pipe)
//  DIV_LAT    4   cycles from divider_en to quotient valid
//  MAX_ITER   16  iteration cap (>=1)
//  ITER_W     5   $clog2(MAX_ITER+1)
// PORTS
//  clk                    in   1         clock
//  rst                    in   1         synchronous, active-high reset
//  go                     in   1         start request, sampled only in IDLE
//  abort                  in   1         cancel run, return to IDLE
//  first_ram_addr         in   ADDR_W    first point address, latched on go
//  last_ram_addr          in   ADDR_W    last point address (inclusive), latched on go
//  ram_rd_en              out  1         point-RAM read strobe
//  ram_addr               out  ADDR_W    point-RAM read address
//  ram_input_reg_en       out  1         load RAM data into classification input reg
//  accumulators_en        out  1         accumulate classified point
//  pipe_regs_clr          out  1         clear accumulators/counters (1 cycle per iteration)
//  divider_en             out  1         start divide for cent_idx
//  cent_idx               out  CENT_W    centroid currently divided/written
//  centroid_wr_en         out  CENT_NUM  one-hot write of new mean into centroid reg
//  convergence_reg_en     out  1         capture old/new centroid diff for cent_idx
//  convergence_regs_clr   out  1         clear convergence regs (with pipe_regs_clr)
//  has_converged          in   1         convergence verdict
//  converge_res_available in   1         verdict valid
//  busy                   out  1         high in every state except IDLE
//  done                   out  1         1-cycle pulse at end of run
//  converged              out  1         result flag, held until next go
//  iter_cnt               out  ITER_W    completed iterations, held until next go
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0, including ram_addr, iter_cnt and converged.
//  States: IDLE, CLEAR, STREAM, DRAIN, DIVIDE, DIV_WAIT, WRITE, CONV_WAIT, DONE.
//  IDLE: on go=1, latch addresses, clear iter_cnt and converged, go to CLEAR. go is ignored in
//   other states.
//  CLEAR (1 cyc): pipe_regs_clr=convergence_regs_clr=1; ram_addr<=first; go to STREAM.
//  STREAM: ram_rd_en=1 every cycle; ram_addr+1 mod 2^ADDR_W.
//   - Leave after the cycle with ram_addr==last.
//   - N = ((last-first) mod 2^ADDR_W)+1 reads; first>last wraps through 0; first==last gives 1 read.
//  Valid shift reg (depth PIPE_DEPTH+1), fed by ram_rd_en:
//   - ram_input_reg_en = tap[0] (read cycle +1); accumulators_en = tap[PIPE_DEPTH] (read cycle
//     +1+PIPE_DEPTH).
//   - Exactly N accumulate pulses per iteration.
//  DRAIN: wait until the shift reg is empty; cent_idx<=0; go to DIVIDE.
//  DIVIDE (1 cyc): divider_en=1 -> DIV_WAIT for DIV_LAT cycles -> WRITE.
//  WRITE (1 cyc): centroid_wr_en[cent_idx]=1 and convergence_reg_en=1.
//   - If cent_idx==CENT_NUM-1, go to CONV_WAIT; else cent_idx+1 and back to DIVIDE.
//  CONV_WAIT: hold until converge_res_available=1 (waits indefinitely), then iter_cnt+1 and:
//   - has_converged=1 -> converged<=1, go to DONE;
//   - else iter_cnt+1==MAX_ITER -> converged<=0, go to DONE;
//   - else go to CLEAR.
//  DONE (1 cyc): done=1, go to IDLE.
//  abort=1 in any non-IDLE state:
//   - next cycle IDLE; valid shift reg flushed; strobes 0; no done pulse; iter_cnt keeps its value.
//   - abort has priority over all transitions; rst has priority over abort.
//  Strobes (rd/en/clr/wr) are registered, never combinational from inputs.
// STRUCTURE
//  kmeans_pkg: state enum ctrl_state_t and shared constants CENT_NUM/CENT_W/ADDR_W.
//  Sub-module kmeans_valid_pipe (param DEPTH): valid shift reg with flush input, all-empty flag.
// TESTING
//  first=10,last=13,PIPE_DEPTH=3: addr 10..13; input_reg_en cyc+1; accum_en 4 pulses, cyc+4.
//  first=510,last=1 (ADDR_W=9): addrs 510,511,0,1 -> 4 reads, 4 accumulates.
//  CENT_NUM=8,DIV_LAT=4: 8 divider_en pulses 6 cyc apart; centroid_wr_en=01,02..80 one-hot.
//  has_converged=1 on iter 3: done pulse once, converged=1, iter_cnt=3, busy low next cycle.
//  MAX_ITER=2, never converge: 2 iterations, done, converged=0, iter_cnt=2.
//  abort mid-STREAM then go: IDLE next cycle, no done, accum_en stops; restart accumulates N.

Source files
------------

// File: rtl/kmeans_iter_ctrl_pkg.sv
// Shared definitions for the k-means iteration controller.
// Holds the controller state type, the centroid/address geometry shared by the
// controller, its interface and the datapath, and a one-hot helper for the
// centroid register write enables.
package kmeans_pkg;

    localparam int CENT_NUM = 8;
    localparam int CENT_W   = $clog2(CENT_NUM);
    localparam int ADDR_W   = 9;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DIVIDE,
        S_DIV_WAIT,
        S_WRITE,
        S_CONV_WAIT,
        S_DONE
    } ctrl_state_t;

    // One-hot select of the centroid register that receives the new mean.
    function automatic logic [CENT_NUM-1:0] cent_onehot(input logic [CENT_W-1:0] idx);
        logic [CENT_NUM-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/kmeans_iter_ctrl_if.sv
// Bundle of every control/status signal between the iteration controller and
// the rest of the k-means core (host handshake, point RAM, classification pipe,
// divider, centroid registers and convergence unit).
//  master : the controller (kmeans_iter_ctrl)
//  slave  : host + datapath side
//  Host      : go, abort, first/last_ram_addr -> ; <- busy, done, converged, iter_cnt
//  Point RAM : <- ram_rd_en, ram_addr
//  Datapath  : <- ram_input_reg_en, accumulators_en, pipe_regs_clr, divider_en,
//               cent_idx, centroid_wr_en, convergence_reg_en, convergence_regs_clr
//  Converge  : has_converged, converge_res_available ->
interface kmeans_iter_ctrl_if #(parameter int ITER_W = 5);
    import kmeans_pkg::*;

    logic                go;
    logic                abort;
    logic [ADDR_W-1:0]   first_ram_addr;
    logic [ADDR_W-1:0]   last_ram_addr;
    logic                ram_rd_en;
    logic [ADDR_W-1:0]   ram_addr;
    logic                ram_input_reg_en;
    logic                accumulators_en;
    logic                pipe_regs_clr;
    logic                divider_en;
    logic [CENT_W-1:0]   cent_idx;
    logic [CENT_NUM-1:0] centroid_wr_en;
    logic                convergence_reg_en;
    logic                convergence_regs_clr;
    logic                has_converged;
    logic                converge_res_available;
    logic                busy;
    logic                done;
    logic                converged;
    logic [ITER_W-1:0]   iter_cnt;

    modport master (
        input  go, abort, first_ram_addr, last_ram_addr,
        input  has_converged, converge_res_available,
        output ram_rd_en, ram_addr, ram_input_reg_en, accumulators_en,
        output pipe_regs_clr, divider_en, cent_idx, centroid_wr_en,
        output convergence_reg_en, convergence_regs_clr,
        output busy, done, converged, iter_cnt
    );

    modport slave (
        output go, abort, first_ram_addr, last_ram_addr,
        output has_converged, converge_res_available,
        input  ram_rd_en, ram_addr, ram_input_reg_en, accumulators_en,
        input  pipe_regs_clr, divider_en, cent_idx, centroid_wr_en,
        input  convergence_reg_en, convergence_regs_clr,
        input  busy, done, converged, iter_cnt
    );

endinterface

// File: rtl/kmeans_iter_ctrl_valid_pipe.sv
// kmeans_valid_pipe: valid-bit shift register that shadows the classification
// pipe. A RAM read strobe enters at tap 0 and walks one tap per cycle.
//  clk, rst  : clock, synchronous active-high reset
//  flush     : clear every tap (run cancelled)
//  in_valid  : read strobe entering the pipe
//  head      : tap 0 (one cycle after the read)
//  tail      : tap DEPTH-1 (last stage)
//  empty     : no valid bit anywhere in the pipe
module kmeans_valid_pipe #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_valid,
    output logic head,
    output logic tail,
    output logic empty
);

    logic [DEPTH-1:0] taps;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            taps <= '0;
        end else begin
            taps <= {taps[DEPTH-2:0], in_valid};
        end
    end

    assign head  = taps[0];
    assign tail  = taps[DEPTH-1];
    assign empty = ~|taps;

endmodule

// File: rtl/kmeans_iter_ctrl.sv
// kmeans_iter_ctrl: top-level sequencer of the k-means core.
// Repeats full iterations (clear, stream points, drain pipe, divide and write
// every centroid, wait for convergence verdict) until convergence or MAX_ITER.
//  clk, rst : clock, synchronous active-high reset
//  bus      : kmeans_iter_ctrl_if master modport (host handshake, RAM strobes,
//             datapath enables, convergence verdict, run status)
// Every strobe is decoded from registered state or taken from a flop, so no
// output depends combinationally on an input.
module kmeans_iter_ctrl
    import kmeans_pkg::*;
#(
    parameter int PIPE_DEPTH = 3,
    parameter int DIV_LAT    = 4,
    parameter int MAX_ITER   = 16,
    parameter int ITER_W     = 5
) (
    input  logic               clk,
    input  logic               rst,
    kmeans_iter_ctrl_if.master bus
);

    localparam int WAIT_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

    ctrl_state_t         state_q, state_d;
    logic [ADDR_W-1:0]   first_q, last_q, addr_q;
    logic [CENT_W-1:0]   cent_idx_q;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [ITER_W-1:0]   iter_q;
    logic [ITER_W-1:0]   iter_next;
    logic                conv_q;
    logic                abort_hit;
    logic                pipe_empty;
    logic                pipe_head;
    logic                pipe_tail;
    logic                rd_en;

    // Abort only matters once a run is in flight and overrides every transition.
    assign abort_hit = bus.abort && (state_q != S_IDLE);
    assign iter_next = iter_q + ITER_W'(1);

    kmeans_valid_pipe #(.DEPTH(PIPE_DEPTH + 1)) u_valid_pipe (
        .clk      (clk),
        .rst      (rst),
        .flush    (abort_hit),
        .in_valid (rd_en),
        .head     (pipe_head),
        .tail     (pipe_tail),
        .empty    (pipe_empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (abort_hit) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:      if (bus.go) state_d = S_CLEAR;
                S_CLEAR:     state_d = S_STREAM;
                S_STREAM:    if (addr_q == last_q) state_d = S_DRAIN;
                S_DRAIN:     if (pipe_empty) state_d = S_DIVIDE;
                S_DIVIDE:    state_d = S_DIV_WAIT;
                S_DIV_WAIT:  if (wait_cnt == WAIT_W'(DIV_LAT - 1)) state_d = S_WRITE;
                S_WRITE:     state_d = (cent_idx_q == CENT_W'(CENT_NUM - 1)) ? S_CONV_WAIT : S_DIVIDE;
                S_CONV_WAIT: begin
                    if (bus.converge_res_available) begin
                        if (bus.has_converged || iter_next == ITER_W'(MAX_ITER)) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_CLEAR;
                        end
                    end
                end
                S_DONE:      state_d = S_IDLE;
                default:     state_d = S_IDLE;
            endcase
        end
    end

    // Address, centroid index, divider wait counter and run status registers.
    // An abort freezes all of them so iter_cnt keeps the completed count.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_q    <= '0;
            last_q     <= '0;
            addr_q     <= '0;
            cent_idx_q <= '0;
            wait_cnt   <= '0;
            iter_q     <= '0;
            conv_q     <= 1'b0;
        end else if (!abort_hit) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.go) begin
                        first_q <= bus.first_ram_addr;
                        last_q  <= bus.last_ram_addr;
                        iter_q  <= '0;
                        conv_q  <= 1'b0;
                    end
                end
                S_CLEAR:    addr_q <= first_q;
                // Natural 2^ADDR_W overflow gives the wrap-around through 0.
                S_STREAM:   addr_q <= addr_q + ADDR_W'(1);
                S_DRAIN:    if (pipe_empty) cent_idx_q <= '0;
                S_DIVIDE:   wait_cnt <= '0;
                S_DIV_WAIT: wait_cnt <= wait_cnt + WAIT_W'(1);
                S_WRITE: begin
                    if (cent_idx_q != CENT_W'(CENT_NUM - 1)) begin
                        cent_idx_q <= cent_idx_q + CENT_W'(1);
                    end
                end
                S_CONV_WAIT: begin
                    if (bus.converge_res_available) begin
                        iter_q <= iter_next;
                        conv_q <= bus.has_converged;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode from the registered state.
    always_comb begin
        rd_en                    = (state_q == S_STREAM);
        bus.ram_rd_en            = rd_en;
        bus.ram_addr             = addr_q;
        bus.ram_input_reg_en     = pipe_head;
        bus.accumulators_en      = pipe_tail;
        bus.pipe_regs_clr        = (state_q == S_CLEAR);
        bus.convergence_regs_clr = (state_q == S_CLEAR);
        bus.divider_en           = (state_q == S_DIVIDE);
        bus.cent_idx             = cent_idx_q;
        bus.centroid_wr_en       = (state_q == S_WRITE) ? cent_onehot(cent_idx_q) : '0;
        bus.convergence_reg_en   = (state_q == S_WRITE);
        bus.busy                 = (state_q != S_IDLE);
        bus.done                 = (state_q == S_DONE);
        bus.converged            = conv_q;
        bus.iter_cnt             = iter_q;
    end

endmodule

// File: tb/tb_kmeans_iter_ctrl.sv
// Testbench for kmeans_iter_ctrl. Two instances: one with MAX_ITER=16 for the
// normal runs, one with MAX_ITER=2 for the iteration cap. For every run the
// bench lays out the expected per-cycle output timeline from the phase lengths
// of an iteration, drives the convergence inputs from that timeline, and a
// compare process checks the selected instance against it each cycle.
module tb_kmeans_iter_ctrl;
    import kmeans_pkg::*;

    localparam int PD  = 3;
    localparam int DL  = 4;
    localparam int ITW = 5;

    typedef struct packed {
        logic                rd;
        logic                in_en;
        logic                acc;
        logic                pclr;
        logic                cclr;
        logic                div;
        logic                creg;
        logic                busy;
        logic                done;
        logic                conv;
        logic                cidx_vld;
        logic                abort;
        logic                avail;
        logic                hc;
        logic [CENT_NUM-1:0] wr;
        logic [ADDR_W-1:0]   addr;
        logic [CENT_W-1:0]   cidx;
        logic [ITW-1:0]      iter;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    kmeans_iter_ctrl_if #(.ITER_W(ITW)) bus_a ();
    kmeans_iter_ctrl_if #(.ITER_W(ITW)) bus_b ();

    kmeans_iter_ctrl #(.PIPE_DEPTH(PD), .DIV_LAT(DL), .MAX_ITER(16), .ITER_W(ITW)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a)
    );
    kmeans_iter_ctrl #(.PIPE_DEPTH(PD), .DIV_LAT(DL), .MAX_ITER(2), .ITER_W(ITW)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
    );

    int                sel;
    logic              go_v, abort_v, avail_v, hc_v;
    logic [ADDR_W-1:0] first_v, last_v;

    assign bus_a.go                     = go_v && (sel == 0);
    assign bus_b.go                     = go_v && (sel == 1);
    assign bus_a.abort                  = abort_v;
    assign bus_b.abort                  = abort_v;
    assign bus_a.first_ram_addr         = first_v;
    assign bus_b.first_ram_addr         = first_v;
    assign bus_a.last_ram_addr          = last_v;
    assign bus_b.last_ram_addr          = last_v;
    assign bus_a.has_converged          = hc_v;
    assign bus_b.has_converged          = hc_v;
    assign bus_a.converge_res_available = avail_v;
    assign bus_b.converge_res_available = avail_v;

    int   checks;
    int   failures;
    logic check_en;
    exp_t exp_cur;
    exp_t tl[$];
    int   model_n;
    logic [ITW-1:0] held_iter [2];
    logic           held_conv [2];
    int   acc_seen, in_seen, div_seen, done_seen;

    // Actual outputs of the selected instance, in the same shape as the model.
    exp_t act;
    always_comb begin
        act = '0;
        if (sel == 0) begin
            act.rd    = bus_a.ram_rd_en;
            act.in_en = bus_a.ram_input_reg_en;
            act.acc   = bus_a.accumulators_en;
            act.pclr  = bus_a.pipe_regs_clr;
            act.cclr  = bus_a.convergence_regs_clr;
            act.div   = bus_a.divider_en;
            act.creg  = bus_a.convergence_reg_en;
            act.busy  = bus_a.busy;
            act.done  = bus_a.done;
            act.conv  = bus_a.converged;
            act.wr    = bus_a.centroid_wr_en;
            act.addr  = bus_a.ram_addr;
            act.cidx  = bus_a.cent_idx;
            act.iter  = bus_a.iter_cnt;
        end else begin
            act.rd    = bus_b.ram_rd_en;
            act.in_en = bus_b.ram_input_reg_en;
            act.acc   = bus_b.accumulators_en;
            act.pclr  = bus_b.pipe_regs_clr;
            act.cclr  = bus_b.convergence_regs_clr;
            act.div   = bus_b.divider_en;
            act.creg  = bus_b.convergence_reg_en;
            act.busy  = bus_b.busy;
            act.done  = bus_b.done;
            act.conv  = bus_b.converged;
            act.wr    = bus_b.centroid_wr_en;
            act.addr  = bus_b.ram_addr;
            act.cidx  = bus_b.cent_idx;
            act.iter  = bus_b.iter_cnt;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s t=%0t actual=%0h required=%0h", name, $time, actual, required);
        end
    endtask

    function automatic exp_t idleEntry(input logic [ITW-1:0] iter, input logic conv);
        exp_t e;
        e      = '0;
        e.iter = iter;
        e.conv = conv;
        return e;
    endfunction

    function automatic exp_t busyEntry(input int iter);
        exp_t e;
        e      = '0;
        e.busy = 1'b1;
        e.iter = ITW'(iter);
        return e;
    endfunction

    // Expected timeline of one run, one entry per cycle starting with the
    // cycle after go is sampled. An iteration is: 1 clear, N reads, PD+2
    // drain, CENT_NUM x (divide + DL wait + write), then the verdict wait.
    task automatic buildRun(input int first, input int last, input int conv_iter,
                            input int max_iter, input int wait_c, input int abort_at);
        exp_t e;
        int   k;
        bit   fin;
        tl.delete();
        model_n = ((last - first + 512) % 512) + 1;
        k   = 0;
        fin = 0;
        while (!fin) begin
            k++;
            e = busyEntry(k - 1);
            e.pclr = 1'b1;
            e.cclr = 1'b1;
            tl.push_back(e);
            for (int i = 0; i < model_n; i++) begin
                e = busyEntry(k - 1);
                e.rd   = 1'b1;
                e.addr = ADDR_W'((first + i) % 512);
                tl.push_back(e);
            end
            for (int i = 0; i < PD + 2; i++) tl.push_back(busyEntry(k - 1));
            for (int c = 0; c < CENT_NUM; c++) begin
                for (int s = 0; s < DL + 2; s++) begin
                    e = busyEntry(k - 1);
                    e.cidx_vld = 1'b1;
                    e.cidx     = CENT_W'(c);
                    if (s == 0) e.div = 1'b1;
                    if (s == DL + 1) begin
                        e.wr[c] = 1'b1;
                        e.creg  = 1'b1;
                    end
                    tl.push_back(e);
                end
            end
            for (int w = 0; w < wait_c; w++) tl.push_back(busyEntry(k - 1));
            e = busyEntry(k - 1);
            e.avail = 1'b1;
            e.hc    = (k == conv_iter);
            tl.push_back(e);
            if (k == conv_iter || k == max_iter) begin
                e = busyEntry(k);
                e.done = 1'b1;
                e.conv = (k == conv_iter);
                tl.push_back(e);
                fin = 1;
            end
        end
        // Each read shows up at the input register one cycle later and at the
        // accumulators PD cycles after that.
        for (int j = 0; j < tl.size(); j++) begin
            if (tl[j].rd) begin
                e = tl[j + 1];      e.in_en = 1'b1; tl[j + 1] = e;
                e = tl[j + 1 + PD]; e.acc   = 1'b1; tl[j + 1 + PD] = e;
            end
        end
        if (abort_at >= 0) begin
            while (tl.size() > abort_at + 1) void'(tl.pop_back());
            e = tl[abort_at];
            e.abort = 1'b1;
            tl[abort_at] = e;
        end
        e = tl[tl.size() - 1];
        for (int i = 0; i < 3; i++) tl.push_back(idleEntry(e.iter, e.conv));
    endtask

    // One run: go cycle, then the timeline. go_mid pulses go mid-run, which
    // must be ignored; the address inputs are scrambled after go so a
    // re-latch would show up as wrong read addresses.
    task automatic applyStimulus(input int s, input int first, input int last, input int conv_iter,
                                 input int wait_c, input int abort_at, input int go_mid);
        buildRun(first, last, conv_iter, (s == 0) ? 16 : 2, wait_c, abort_at);
        @(posedge clk); #1;
        sel       = s;
        first_v   = ADDR_W'(first);
        last_v    = ADDR_W'(last);
        go_v      = 1'b1;
        abort_v   = 1'b0;
        avail_v   = 1'b0;
        hc_v      = 1'b0;
        exp_cur   = idleEntry(held_iter[s], held_conv[s]);
        acc_seen  = 0;
        in_seen   = 0;
        div_seen  = 0;
        done_seen = 0;
        for (int j = 0; j < tl.size(); j++) begin
            @(posedge clk); #1;
            go_v    = (j == go_mid);
            first_v = '0;
            last_v  = '0;
            abort_v = tl[j].abort;
            avail_v = tl[j].avail;
            hc_v    = tl[j].hc;
            exp_cur = tl[j];
        end
        held_iter[s] = tl[tl.size() - 1].iter;
        held_conv[s] = tl[tl.size() - 1].conv;
        @(negedge clk); #1;
    endtask

    // Per-cycle comparison against the model timeline.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("ram_rd_en", act.rd, exp_cur.rd);
            checkOutput("ram_input_reg_en", act.in_en, exp_cur.in_en);
            checkOutput("accumulators_en", act.acc, exp_cur.acc);
            checkOutput("pipe_regs_clr", act.pclr, exp_cur.pclr);
            checkOutput("convergence_regs_clr", act.cclr, exp_cur.cclr);
            checkOutput("divider_en", act.div, exp_cur.div);
            checkOutput("centroid_wr_en", act.wr, exp_cur.wr);
            checkOutput("convergence_reg_en", act.creg, exp_cur.creg);
            checkOutput("busy", act.busy, exp_cur.busy);
            checkOutput("done", act.done, exp_cur.done);
            checkOutput("converged", act.conv, exp_cur.conv);
            checkOutput("iter_cnt", act.iter, exp_cur.iter);
            if (exp_cur.rd) checkOutput("ram_addr", act.addr, exp_cur.addr);
            if (exp_cur.cidx_vld) checkOutput("cent_idx", act.cidx, exp_cur.cidx);
            if (act.acc === 1'b1) acc_seen++;
            if (act.in_en === 1'b1) in_seen++;
            if (act.div === 1'b1) div_seen++;
            if (act.done === 1'b1) done_seen++;
        end
    end

    initial begin
        int cnt, fa, d0, d1;
        checks    = 0;
        failures  = 0;
        check_en  = 1'b0;
        sel       = 0;
        go_v      = 1'b0;
        abort_v   = 1'b0;
        avail_v   = 1'b0;
        hc_v      = 1'b0;
        first_v   = '0;
        last_v    = '0;
        held_iter[0] = '0; held_iter[1] = '0;
        held_conv[0] = 1'b0; held_conv[1] = 1'b0;
        acc_seen = 0; in_seen = 0; div_seen = 0; done_seen = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_cur  = idleEntry('0, 1'b0);
        check_en = 1'b1;
        checkOutput("reset_busy_a", bus_a.busy, 0);
        checkOutput("reset_ram_addr_a", bus_a.ram_addr, 0);
        checkOutput("reset_iter_cnt_a", bus_a.iter_cnt, 0);
        checkOutput("reset_converged_a", bus_a.converged, 0);
        checkOutput("reset_cent_idx_a", bus_a.cent_idx, 0);
        checkOutput("reset_busy_b", bus_b.busy, 0);
        checkOutput("reset_iter_cnt_b", bus_b.iter_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] run 1: addresses 10..13, converge on first verdict");
        applyStimulus(0, 10, 13, 1, 2, -1, -1);
        cnt = 0; fa = -1; d0 = -1; d1 = -1;
        for (int j = 0; j < tl.size(); j++) begin
            if (tl[j].acc) begin
                cnt++;
                if (fa < 0) fa = j;
            end
            if (tl[j].div) begin
                if (d0 < 0) d0 = j;
                else if (d1 < 0) d1 = j;
            end
        end
        checkOutput("model_n_10_13", model_n, 4);
        checkOutput("model_acc_count", cnt, 4);
        checkOutput("model_first_acc_cycle", fa, 5);
        checkOutput("model_first_div_cycle", d0, 10);
        checkOutput("model_div_spacing", d1 - d0, 6);
        checkOutput("run1_acc_pulses", acc_seen, 4);
        checkOutput("run1_in_reg_pulses", in_seen, 4);
        checkOutput("run1_div_pulses", div_seen, 8);
        checkOutput("run1_done_pulses", done_seen, 1);
        checkOutput("run1_iter_cnt", act.iter, 1);
        checkOutput("run1_converged", act.conv, 1);

        $display("[TB] run 2: wrap 510..1, stray go mid-stream");
        applyStimulus(0, 510, 1, 1, 0, -1, 2);
        checkOutput("model_n_wrap", model_n, 4);
        checkOutput("run2_acc_pulses", acc_seen, 4);
        checkOutput("run2_done_pulses", done_seen, 1);

        $display("[TB] run 3: single point, converge on third verdict");
        applyStimulus(0, 100, 100, 3, 1, -1, -1);
        checkOutput("run3_done_pulses", done_seen, 1);
        checkOutput("run3_iter_cnt", act.iter, 3);
        checkOutput("run3_converged", act.conv, 1);
        checkOutput("run3_acc_pulses", acc_seen, 3);
        checkOutput("run3_div_pulses", div_seen, 24);
        checkOutput("run3_busy_after", act.busy, 0);

        $display("[TB] run 4: abort mid-stream");
        applyStimulus(0, 20, 29, 1, 0, 5, -1);
        checkOutput("run4_done_pulses", done_seen, 0);
        checkOutput("run4_acc_pulses", acc_seen, 1);
        checkOutput("run4_busy_after", act.busy, 0);
        checkOutput("run4_iter_cnt", act.iter, 0);

        $display("[TB] run 5: restart after abort");
        applyStimulus(0, 20, 29, 1, 0, -1, -1);
        checkOutput("run5_acc_pulses", acc_seen, 10);
        checkOutput("run5_done_pulses", done_seen, 1);

        $display("[TB] run 6: MAX_ITER=2 instance, never converges");
        applyStimulus(1, 0, 2, 0, 0, -1, -1);
        checkOutput("run6_done_pulses", done_seen, 1);
        checkOutput("run6_iter_cnt", act.iter, 2);
        checkOutput("run6_converged", act.conv, 0);
        checkOutput("run6_acc_pulses", acc_seen, 6);

        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
